// File: rtl/strait_pkg.sv
// Shared types and constants for the P-input mux scheduler and the mux array it drives.
package strait_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STREAM,
    DRAIN,
    DONE
  } state_e;

  localparam int DEF_ROWS  = 4;
  localparam int DEF_COLS  = 4;
  localparam int DEF_LEN_W = 8;

  // Mux select encoding shared with the P-input mux datapath
  localparam logic SEL_TOP  = 1'b0;
  localparam logic SEL_LEFT = 1'b1;

endpackage

// File: rtl/p_mux_skew_gen.sv
// Wavefront select generator: row r switches to the left stream once the phase count reaches r.
module p_mux_skew_gen
  import strait_pkg::*;
#(
  parameter int ROWS  = DEF_ROWS,
  parameter int CNT_W = 8
) (
  input  logic             phase_active,
  input  logic [CNT_W-1:0] cnt,
  output logic [ROWS-1:0]  sel_vec
);

  always_comb begin
    sel_vec = '0;
    for (int r = 0; r < ROWS; r++) begin
      sel_vec[r] = (phase_active && (cnt >= CNT_W'(r))) ? SEL_LEFT : SEL_TOP;
    end
  end

endmodule

// File: rtl/p_mux_scheduler.sv
// Load/stream/drain sequencer for a row of P-input muxes; define STRAIT_SEL_SKEW_EN
// for a wavefront-skewed sel_vec, otherwise all rows switch together.
module p_mux_scheduler
  import strait_pkg::*;
#(
  parameter int ROWS  = DEF_ROWS,
  parameter int COLS  = DEF_COLS,
  parameter int LEN_W = DEF_LEN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [LEN_W-1:0] stream_len,
  output logic [ROWS-1:0]  sel_vec,
  output logic             top_ready,
  output logic             left_ready,
  output logic             busy,
  output logic             done
);

  localparam int DRAIN_LEN = ROWS + COLS - 1;
  localparam int DRAIN_W   = $clog2(DRAIN_LEN + 1);
  // cnt runs through STREAM and DRAIN without restarting, so it must hold len + drain length
  localparam int CNT_W     = ((LEN_W > DRAIN_W) ? LEN_W : DRAIN_W) + 1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [LEN_W-1:0]   len_q, len_d;

  logic [CNT_W-1:0]   len_ext;
  logic [CNT_W-1:0]   load_last;
  logic [CNT_W-1:0]   stream_last;
  logic [CNT_W-1:0]   drain_last;
  logic [CNT_W-1:0]   skew_cnt;
  logic               phase_active;

  assign len_ext     = CNT_W'(len_q);
  assign load_last   = CNT_W'(ROWS - 1);
  assign stream_last = len_ext - CNT_W'(1);
  assign drain_last  = len_ext + CNT_W'(DRAIN_LEN - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    if ((state_q != IDLE) && abort) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && !abort) begin
            state_d = LOAD;
            cnt_d   = '0;
            len_d   = stream_len;
          end
        end
        LOAD: begin
          if (cnt_q == load_last) begin
            cnt_d   = '0;
            state_d = (len_q == '0) ? DRAIN : STREAM;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        STREAM: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == stream_last) begin
            state_d = DRAIN;
          end
        end
        DRAIN: begin
          if (cnt_q == drain_last) begin
            state_d = DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    top_ready    = (state_q == LOAD);
    left_ready   = (state_q == STREAM);
    busy         = (state_q != IDLE);
    done         = (state_q == DONE);
    phase_active = (state_q == STREAM) || (state_q == DRAIN);
  end

  // Without skew, a saturated count makes every row select left for the whole active phase
`ifdef STRAIT_SEL_SKEW_EN
  assign skew_cnt = cnt_q;
`else
  assign skew_cnt = '1;
`endif

  p_mux_skew_gen #(
    .ROWS  (ROWS),
    .CNT_W (CNT_W)
  ) u_skew_gen (
    .phase_active (phase_active),
    .cnt          (skew_cnt),
    .sel_vec      (sel_vec)
  );

endmodule
